// File: rtl/frame_sequencer.sv
// Command-driven frame timing generator: emits frameStart/frameEnd/burstDone
// for a single frame or a burst, with abort handling and a post-reset settle cycle.
module frame_sequencer #(
    parameter int unsigned FRAME_LEN_W = 16,
    parameter int unsigned BURST_W     = 8,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic                   cmdMode,
    input  logic [FRAME_LEN_W-1:0] cmdFrameLen,
    input  logic [BURST_W-1:0]     cmdBurstLen,
    input  logic                   abort,
    output logic                   frameStart,
    output logic                   frameEnd,
    output logic                   burstDone,
    output logic                   mode,
    output logic                   busy,
    output logic [BURST_W-1:0]     frameCount
);

    typedef enum logic [2:0] {StIdle, StStart, StActive, StGap, StClose} state_e;

    localparam logic [FRAME_LEN_W-1:0] MinLen  = FRAME_LEN_W'(2);
    localparam logic [FRAME_LEN_W-1:0] GapLoad = FRAME_LEN_W'(GAP_CYCLES - 1);
    localparam logic [BURST_W-1:0]     OneB    = BURST_W'(1);

    state_e                 state_q, state_d;
    logic [FRAME_LEN_W-1:0] cnt_q, cnt_d;
    logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
    logic [BURST_W-1:0]     burst_len_q, burst_len_d;
    logic [BURST_W-1:0]     frame_count_d;
    logic                   mode_d;
    logic                   close_frame_q, close_frame_d;
    logic                   settle_q;
    logic                   accept;
    logic                   frame_end_d, burst_done_d;

    assign accept = cmdValid && cmdReady && !settle_q && (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_len_d   = frame_len_q;
        burst_len_d   = burst_len_q;
        frame_count_d = frameCount;
        mode_d        = mode;
        close_frame_d = close_frame_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d       = StStart;
                    mode_d        = cmdMode;
                    frame_count_d = '0;
                    close_frame_d = 1'b0;
                    frame_len_d   = (cmdFrameLen < MinLen) ? MinLen : cmdFrameLen;
                    burst_len_d   = (!cmdMode || cmdBurstLen == '0) ? OneB : cmdBurstLen;
                end
            end
            StStart: begin
                if (abort) begin
                    state_d       = StClose;
                    close_frame_d = 1'b1;
                end else begin
                    state_d = StActive;
                    cnt_d   = frame_len_q - MinLen;
                end
            end
            StActive: begin
                if (cnt_q == '0) begin
                    // Frame completes this cycle; an abort here finds no open frame.
                    frame_count_d = frameCount + OneB;
                    if (frameCount == burst_len_q - OneB) begin
                        state_d = StIdle;
                    end else if (abort) begin
                        state_d       = StClose;
                        close_frame_d = 1'b0;
                    end else begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end
                end else if (abort) begin
                    state_d       = StClose;
                    close_frame_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - FRAME_LEN_W'(1);
                end
            end
            StGap: begin
                if (abort) begin
                    state_d       = StClose;
                    close_frame_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q - FRAME_LEN_W'(1);
                end
            end
            StClose: begin
                state_d = StIdle;
                if (close_frame_q) begin
                    frame_count_d = frameCount + OneB;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output pulses are decoded from the next state so they leave straight from flops.
    always_comb begin
        frame_end_d  = ((state_d == StActive) && (cnt_d == '0)) ||
                       ((state_d == StClose) && close_frame_d);
        burst_done_d = mode_d &&
                       (((state_d == StActive) && (cnt_d == '0) &&
                         (frame_count_d == burst_len_d - OneB)) ||
                        (state_d == StClose));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            frame_len_q   <= MinLen;
            burst_len_q   <= OneB;
            close_frame_q <= 1'b0;
            settle_q      <= 1'b1;
            cmdReady      <= 1'b0;
            frameStart    <= 1'b0;
            frameEnd      <= 1'b0;
            burstDone     <= 1'b0;
            mode          <= 1'b0;
            busy          <= 1'b0;
            frameCount    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_len_q   <= frame_len_d;
            burst_len_q   <= burst_len_d;
            close_frame_q <= close_frame_d;
            settle_q      <= 1'b0;
            cmdReady      <= (state_d == StIdle);
            frameStart    <= (state_d == StStart);
            frameEnd      <= frame_end_d;
            burstDone     <= burst_done_d;
            mode          <= mode_d;
            busy          <= (state_d != StIdle);
            frameCount    <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: cycle-by-cycle comparison against a schedule model built
// from the timing formulas, plus literal event-position checks for directed commands.
module tb_frame_sequencer;

    localparam int unsigned FLW = 16;
    localparam int unsigned BW  = 8;
    localparam int          GAP = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmdValid = 1'b0;
    logic           cmdReady;
    logic           cmdMode = 1'b0;
    logic [FLW-1:0] cmdFrameLen = '0;
    logic [BW-1:0]  cmdBurstLen = '0;
    logic           abort = 1'b0;
    logic           frameStart, frameEnd, burstDone, mode, busy;
    logic [BW-1:0]  frameCount;

    frame_sequencer #(
        .FRAME_LEN_W (FLW),
        .BURST_W     (BW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdMode     (cmdMode),
        .cmdFrameLen (cmdFrameLen),
        .cmdBurstLen (cmdBurstLen),
        .abort       (abort),
        .frameStart  (frameStart),
        .frameEnd    (frameEnd),
        .burstDone   (burstDone),
        .mode        (mode),
        .busy        (busy),
        .frameCount  (frameCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct packed {
        logic       fs;
        logic       fe;
        logic       bd;
        logic       busy;
        logic       ready;
        logic       mode;
        logic [7:0] cnt;
    } exp_t;

    // Model state: the last accepted command and, if any, the cycle its abort took effect.
    bit m_has = 1'b0, m_ab = 1'b0, m_mode = 1'b0, m_settle = 1'b1;
    int m_t = 0, m_L = 2, m_B = 1, m_a = 0;

    function automatic exp_t model_at(int n);
        exp_t e;
        int   r, p, e_last, lim, k, off, ra, ka, offa, done_a;
        bit   open_a;
        e = '0;
        if (!m_has) begin
            e.ready = !m_settle;
            return e;
        end
        e.mode = m_mode;
        r      = n - m_t;
        p      = m_L + GAP;
        e_last = m_B * m_L + (m_B - 1) * GAP;
        ra     = m_a - m_t;
        lim    = m_ab ? ra : e_last;
        if (r <= lim) begin
            k      = (r - 1) / p;
            off    = (r - 1) % p;
            e.busy = 1'b1;
            e.fs   = (off == 0);
            e.fe   = (off == m_L - 1);
            e.bd   = m_mode && (r == e_last);
            e.cnt  = 8'(k + ((off >= m_L) ? 1 : 0));
        end else begin
            if (m_ab) begin
                ka     = (ra - 1) / p;
                offa   = (ra - 1) % p;
                done_a = ka + ((offa >= m_L - 1) ? 1 : 0);
                open_a = (offa < m_L - 1);
            end else begin
                done_a = m_B;
                open_a = 1'b0;
            end
            if (m_ab && r == ra + 1) begin
                e.busy = 1'b1;
                e.fe   = open_a;
                e.bd   = m_mode;
                e.cnt  = 8'(done_a);
            end else begin
                e.ready = 1'b1;
                e.cnt   = 8'(done_a + int'(open_a));
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then fold this cycle's inputs into it.
    initial forever begin
        exp_t        e;
        logic [13:0] act;
        int          ra, e_last;
        @(negedge clk);
        if (!reset_n) begin
            m_has    = 1'b0;
            m_settle = 1'b1;
            e        = '0;
        end else begin
            e = model_at(cyc);
        end
        act = {frameStart, frameEnd, burstDone, busy, cmdReady, mode, frameCount};
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL cycle_cmp @%0d: got %h expected %h", cyc, act, e);
        end
        if (reset_n) begin
            if (e.ready && cmdValid) begin
                m_has  = 1'b1;
                m_ab   = 1'b0;
                m_t    = cyc;
                m_mode = cmdMode;
                m_L    = (int'(cmdFrameLen) < 2) ? 2 : int'(cmdFrameLen);
                m_B    = (!cmdMode || cmdBurstLen == '0) ? 1 : int'(cmdBurstLen);
            end else if (m_has && !m_ab && abort) begin
                ra     = cyc - m_t;
                e_last = m_B * m_L + (m_B - 1) * GAP;
                if (ra >= 1 && ra < e_last) begin
                    m_ab = 1'b1;
                    m_a  = cyc;
                end
            end
            m_settle = 1'b0;
        end
    end

    logic [31:0] fs_m, fe_m, bd_m, rdy_m, md_m;
    logic [7:0]  cap_cnt [32];

    // Issue one command at cycle t and record where each output fires relative to t.
    task automatic run_cmd(input bit md, input int len, input int bl, input int ab_r,
                           input bit noise);
        fs_m = '0; fe_m = '0; bd_m = '0; rdy_m = '0; md_m = '0;
        @(posedge clk);
        #1;
        cmdValid    = 1'b1;
        cmdMode     = md;
        cmdFrameLen = FLW'(len);
        cmdBurstLen = BW'(bl);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            fs_m[i]    = frameStart;
            fe_m[i]    = frameEnd;
            bd_m[i]    = burstDone;
            rdy_m[i]   = cmdReady;
            md_m[i]    = mode;
            cap_cnt[i] = frameCount;
            @(posedge clk);
            #1;
            cmdValid = noise && (i >= 1) && (i <= 12) && (i % 3 == 0);
            cmdMode  = noise ? 1'($urandom_range(0, 1)) : md;
            abort    = (i + 1 == ab_r);
        end
        cmdValid = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        logic [7:0] s_rdy, s_fs, s_fe;
        logic [13:0] outs;

        // cmdValid held through reset release: accept only on the second cycle.
        cmdValid    = 1'b1;
        cmdFrameLen = FLW'(3);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        s_rdy = '0; s_fs = '0; s_fe = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_rdy[i] = cmdReady;
            s_fs[i]  = frameStart;
            s_fe[i]  = frameEnd;
            @(posedge clk);
            #1;
            if (i == 1) cmdValid = 1'b0;
        end
        check("settle_ready", 64'(s_rdy[5:0]), 64'h22);
        check("settle_start", 64'(s_fs[5:0]), 64'h04);
        check("settle_end", 64'(s_fe[5:0]), 64'h10);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            cmdValid    = ($urandom_range(0, 2) == 0);
            cmdMode     = 1'($urandom_range(0, 1));
            cmdFrameLen = FLW'($urandom_range(0, 8));
            cmdBurstLen = BW'($urandom_range(0, 5));
            abort       = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        cmdValid = 1'b0;
        abort    = 1'b0;
        repeat (80) @(posedge clk);

        run_cmd(1'b0, 5, 0, 0, 1'b0);
        check("single_start", 64'(fs_m), 64'h2);
        check("single_end", 64'(fe_m), 64'h20);
        check("single_bdone", 64'(bd_m), 64'h0);
        check("single_count", 64'(cap_cnt[6]), 64'd1);
        check("single_ready", 64'(rdy_m & 32'h7F), 64'h41);

        run_cmd(1'b1, 4, 3, 0, 1'b1);
        check("burst_start", 64'(fs_m), 64'h2082);
        check("burst_end", 64'(fe_m), 64'h10410);
        check("burst_bdone", 64'(bd_m), 64'h10000);
        check("burst_count", 64'(cap_cnt[17]), 64'd3);
        check("burst_mode", 64'(md_m & 32'h1FFFE), 64'h1FFFE);

        run_cmd(1'b1, 0, 0, 0, 1'b0);
        check("clamp0_start", 64'(fs_m), 64'h2);
        check("clamp0_end", 64'(fe_m), 64'h4);
        check("clamp0_bdone", 64'(bd_m), 64'h4);

        run_cmd(1'b0, 1, 0, 0, 1'b0);
        check("clamp1_end", 64'(fe_m), 64'h4);
        check("clamp1_bdone", 64'(bd_m), 64'h0);

        run_cmd(1'b1, 4, 3, 8, 1'b0);
        check("abort_act_start", 64'(fs_m), 64'h82);
        check("abort_act_end", 64'(fe_m), 64'h210);
        check("abort_act_bdone", 64'(bd_m), 64'h200);
        check("abort_act_count", 64'(cap_cnt[10]), 64'd2);
        check("abort_act_ready", 64'(rdy_m & 32'h600), 64'h400);

        run_cmd(1'b1, 4, 3, 5, 1'b0);
        check("abort_gap_start", 64'(fs_m), 64'h2);
        check("abort_gap_end", 64'(fe_m), 64'h10);
        check("abort_gap_bdone", 64'(bd_m), 64'h40);
        check("abort_gap_count", 64'(cap_cnt[7]), 64'd1);

        // Reset mid-frame: outputs drop without waiting for a clock edge.
        @(posedge clk);
        #1;
        cmdValid    = 1'b1;
        cmdMode     = 1'b1;
        cmdFrameLen = FLW'(6);
        cmdBurstLen = BW'(2);
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_busy", 64'(busy), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        outs = {frameStart, frameEnd, burstDone, busy, cmdReady, mode, frameCount};
        check("async_reset_outs", 64'(outs), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_settle_low", 64'(cmdReady), 64'd0);
        @(negedge clk);
        check("reset_settle_high", 64'(cmdReady), 64'd1);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Command-driven frame timing generator that sits directly upstream of the frame-progress FSM. It accepts one capture command at a time through a valid/ready handshake. For that command it drives `frameStart`, `frameEnd`, `burstDone` and `mode` with the spacing the FSM needs. It produces either one frame (single mode) or a burst of N frames (burst mode) of programmable length, and it supports an abort that cleanly closes any open frame or burst.

## Interface
- `FRAME_LEN_W`, default 16: width of the frame-length field and the cycle counter.
- `BURST_W`, default 8: width of the burst-length field and the frame counter.
- `GAP_CYCLES`, default 2: number of idle cycles between one frame's `frameEnd` and the next `frameStart` within a burst. Legal values are ≥1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmdValid` in 1: a command is present.
- `cmdReady` out 1: the block can accept a command.
- `cmdMode` in 1: 0 selects single frame, 1 selects burst.
- `cmdFrameLen` in FRAME_LEN_W: frame length in cycles, counted from `frameStart` through `frameEnd` inclusive.
- `cmdBurstLen` in BURST_W: number of frames in a burst.
- `abort` in 1: terminate the current command.
- `frameStart` out 1: one-cycle pulse on the first cycle of a frame.
- `frameEnd` out 1: one-cycle pulse on the last cycle of a frame.
- `burstDone` out 1: one-cycle pulse that closes a burst.
- `mode` out 1: latched `cmdMode`, held stable from accept until the block returns to IDLE.
- `busy` out 1: high whenever the state is not IDLE.
- `frameCount` out BURST_W: number of frames completed in the current command.

## Operation
- States:
  - IDLE: `cmdReady` is 1.
  - START: `frameStart` is 1.
  - ACTIVE: the frame body; `frameEnd` is 1 on its final cycle.
  - GAP: inter-frame idle time within a burst.
  - CLOSE: abort termination.
- All outputs are registered and decoded from state and counters. They are glitch-free single-cycle pulses.
- Accept: a command is accepted when `cmdValid` and `cmdReady` are both 1 in IDLE. On accept:
  - `mode`, the effective frame length and the effective burst length are latched.
  - `frameCount` clears to 0.
  - The next state is START.
- Effective lengths:
  - Frame length is max(`cmdFrameLen`, 2). The floor of 2 guarantees `frameEnd` is never coincident with `frameStart`.
  - Burst length is 1 if `cmdMode` is 0 or `cmdBurstLen` is 0; otherwise it is `cmdBurstLen`.
- START → ACTIVE. The frame cycle counter is loaded so that `frameEnd` fires exactly at frame length minus 1 cycles after `frameStart`.
- Frame completion on the `frameEnd` cycle:
  - `frameCount` increments.
  - If this was the last frame, `burstDone` is asserted in the same cycle when `mode` is 1, and the next state is IDLE.
  - Otherwise the next state is GAP.
- GAP lasts exactly GAP_CYCLES cycles and then goes to START.
- `cmdValid` while busy is ignored; commands are never queued.
- Abort:
  - When `abort` is sampled high in START, ACTIVE or GAP, the next state is CLOSE.
  - CLOSE lasts one cycle. It pulses `frameEnd` if a frame is open, meaning the abort was sampled in START or ACTIVE, and pulses `burstDone` if `mode` is 1.
  - CLOSE is followed by IDLE.
  - `abort` in IDLE or CLOSE has no effect.
  - An abort that lands on the natural last `frameEnd` cycle is ignored, because completion wins.
  - `frameCount` increments on a CLOSE `frameEnd`.
- Post-reset settle: `cmdReady` is held 0 for the first cycle after `reset_n` deasserts, so the downstream FSM is in its wait state before any `frameStart`.

## Timing
- Reset values:
  - State is IDLE.
  - `cmdReady`, `frameStart`, `frameEnd`, `burstDone`, `mode` and `busy` are 0.
  - `frameCount` is 0.
  - The settle flag is armed.
- Reset asserted mid-frame aborts immediately with no closing pulses; all outputs drop asynchronously.
- With accept at cycle t:
  - `frameStart` is at t+1.
  - `frameEnd` is at t+L, where L is the effective frame length.
  - In a burst, the next `frameStart` is at t+L+GAP_CYCLES+1, giving a frame period of L+GAP_CYCLES.
- The last `frameEnd` (and `burstDone`) is at t+B·L+(B−1)·GAP_CYCLES, where B is the effective burst length. `cmdReady` returns to 1 on the following cycle.
- With abort sampled at cycle a, the CLOSE pulses appear at a+1 and `cmdReady` is 1 at a+2.
- The minimum spacing from a closing pulse to the next `frameStart` is 2 cycles: IDLE for one cycle, then START.

## Test plan
- Single frame: accept at cycle 0 with mode=0, len=5. Expect `frameStart`@1, `frameEnd`@5, no `burstDone`, `frameCount`=1, `cmdReady`@6.
- Burst: accept at cycle 0 with mode=1, len=4, burst=3, GAP=2.
  - Expect `frameStart`@1, 7 and 13.
  - Expect `frameEnd`@4, 10 and 16.
  - Expect `burstDone` only @16 and `frameCount`=3.
- Clamping: len=0, burst=0, mode=1. Expect one frame with `frameStart`@1 and `frameEnd`+`burstDone`@2. With len=1 and mode=0, expect `frameEnd`@2.
- Abort: abort mid-burst in ACTIVE of frame 2 at cycle 8. Expect `frameEnd`+`burstDone`@9, `frameCount`=2, `cmdReady`@10. Abort sampled in GAP at cycle 5 gives `burstDone` only @6.
- Handshake and settle:
  - `cmdValid` held high through reset release: `cmdReady`=0 on the first cycle and the accept happens on the second.
  - `cmdValid` pulses while busy are dropped and no extra frames are produced.
  - `mode` stays constant across the whole burst even when `cmdMode` toggles.
- Reset mid-frame: `reset_n` low during ACTIVE. All outputs go to 0 immediately with no `frameEnd`, and after release the settle cycle is observed again.
